// File: rtl/parity_link_pkg.sv
// Shared definitions for the XOR-parity serial link: receiver states, line
// levels and the word parity helper used by transmitter, receiver and bench.
package parity_link_pkg;

   localparam int unsigned STATE_W    = 2;
   localparam int unsigned MAX_DATA_W = 16;

   typedef logic [STATE_W-1:0] state_t;

   typedef enum state_t {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

   // XOR-reduction of a data word; zero-extension leaves the result unchanged.
   function automatic logic parity_of(input logic [MAX_DATA_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Receiver-side bus: line strobe/data in, decoded word and status out.
interface parity_frame_rx_if #(
   parameter int unsigned DATA_W = 8
) ();

   logic              bit_en;
   logic              sdi;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              parity_err;
   logic              frame_err;
   logic              busy;

   modport master (
      output bit_en, sdi,
      input  rx_data, rx_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  bit_en, sdi,
      output rx_data, rx_valid, parity_err, frame_err, busy
   );

endinterface

// File: rtl/parity_accum.sv
// One-bit XOR accumulator with synchronous clear-to-INIT and enable.
module parity_accum #(
   parameter logic INIT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic acc
);

   logic acc_q;
   logic acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = INIT;
      end else if (en) begin
         acc_d = acc_q ^ din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Define PARITY_ODD_EN for odd parity; even parity otherwise.
module parity_frame_rx
   import parity_link_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   parity_frame_rx_if.slave   bus
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef PARITY_ODD_EN
   localparam logic ACC_INIT = 1'b1;
`else
   localparam logic ACC_INIT = 1'b0;
`endif

   state_e            state_q,      state_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic [DATA_W-1:0] shift_q,      shift_d;
   logic [DATA_W-1:0] rx_data_q,    rx_data_d;
   logic              rx_valid_q,   rx_valid_d;
   logic              parity_err_q, parity_err_d;
   logic              frame_err_q,  frame_err_d;
   logic              busy_q,       busy_d;

   logic              acc_clr_c;
   logic              acc_en_c;
   logic              acc;

   parity_accum #(
      .INIT (ACC_INIT)
   ) u_accum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr_c),
      .en    (acc_en_c),
      .din   (bus.sdi),
      .acc   (acc)
   );

   // Next-state and datapath; everything holds unless a strobe is present.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      acc_clr_c    = 1'b0;
      acc_en_c     = 1'b0;

      if (bus.bit_en) begin
         case (state_q)
            IDLE: begin
               if (bus.sdi == START_BIT) begin
                  state_d   = DATA;
                  cnt_d     = '0;
                  acc_clr_c = 1'b1;
               end
            end
            DATA: begin
               shift_d[cnt_q] = bus.sdi;
               acc_en_c       = 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = PARITY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PARITY: begin
               acc_en_c = 1'b1;
               state_d  = STOP;
            end
            STOP: begin
               rx_data_d    = shift_q;
               parity_err_d = acc;
               frame_err_d  = (bus.sdi != LINE_IDLE);
               rx_valid_d   = 1'b1;
               state_d      = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx; expectations come from frame-level
// rules (word parity, stop level) rather than from the receiver's internals.
module tb_parity_frame_rx;
   import parity_link_pkg::*;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned FRAME_LEN = DATA_W + 3;

`ifdef PARITY_ODD_EN
   localparam logic ODD = 1'b1;
`else
   localparam logic ODD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks    = 0;
   int   errors    = 0;
   int   strobe_no = 0;

   always #5 clk = ~clk;

   parity_frame_rx_if #(.DATA_W(DATA_W)) bus_if ();

   parity_frame_rx #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   function automatic logic exp_perr(input logic [DATA_W-1:0] d, input logic p);
      return parity_of(MAX_DATA_W'(d)) ^ p ^ ODD;
   endfunction

   // One strobe preceded by `gap` non-strobe cycles carrying random sdi glitches.
   task automatic strobe(input logic b, input int unsigned gap,
                         output logic v_gap, output logic v_edge);
      v_gap = 1'b0;
      repeat (gap) begin
         @(negedge clk);
         bus_if.bit_en = 1'b0;
         bus_if.sdi    = 1'($urandom);
         @(posedge clk); #1;
         if (bus_if.rx_valid) v_gap = 1'b1;
      end
      @(negedge clk);
      bus_if.bit_en = 1'b1;
      bus_if.sdi    = b;
      @(posedge clk); #1;
      v_edge = bus_if.rx_valid;
      strobe_no++;
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop,
                             input int unsigned gap, output int n_valid, output int valid_at,
                             output logic busy_mid, output logic [DATA_W-1:0] data_pre);
      logic bits [FRAME_LEN];
      logic vg, ve;
      bits[0] = START_BIT;
      for (int i = 0; i < DATA_W; i++) bits[1+i] = d[i];
      bits[DATA_W+1] = p;
      bits[DATA_W+2] = stop;
      n_valid  = 0;
      valid_at = -1;
      busy_mid = 1'b0;
      data_pre = '0;
      for (int k = 0; k < FRAME_LEN; k++) begin
         strobe(bits[k], gap, vg, ve);
         if (vg) n_valid++;
         if (ve) begin n_valid++; valid_at = strobe_no; end
         if (k == 0) busy_mid = bus_if.busy;
         if (k == FRAME_LEN - 2) data_pre = bus_if.rx_data;
      end
   endtask

   task automatic idle(input int unsigned n, input logic with_strobe, output logic v);
      v = 1'b0;
      repeat (n) begin
         @(negedge clk);
         bus_if.bit_en = with_strobe;
         bus_if.sdi    = LINE_IDLE;
         @(posedge clk); #1;
         if (bus_if.rx_valid) v = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_if.bit_en = 1'b0;
      bus_if.sdi    = LINE_IDLE;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus_if.rx_data !== '0) begin errors++; $display("FAIL reset_rx_data got %h exp 0", bus_if.rx_data); end
      checks++; if (bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", bus_if.rx_valid); end
      checks++; if (bus_if.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b exp 0", bus_if.parity_err); end
      checks++; if (bus_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", bus_if.frame_err); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus_if.busy); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_good_frame(input logic p, input string tag);
      int n, at; logic bm, v; logic [DATA_W-1:0] dp;
      send_frame(8'hA5, p, 1'b1, 0, n, at, bm, dp);
      checks++; if (n !== 1 || at !== strobe_no) begin errors++; $display("FAIL %s_valid got count %0d at %0d exp 1 at %0d", tag, n, at, strobe_no); end
      checks++; if (bus_if.rx_data !== 8'hA5) begin errors++; $display("FAIL %s_data got %h exp a5", tag, bus_if.rx_data); end
      checks++; if (bus_if.parity_err !== exp_perr(8'hA5, p)) begin errors++; $display("FAIL %s_perr got %b exp %b", tag, bus_if.parity_err, exp_perr(8'hA5, p)); end
      checks++; if (bus_if.frame_err !== 1'b0) begin errors++; $display("FAIL %s_ferr got %b exp 0", tag, bus_if.frame_err); end
      checks++; if (bm !== 1'b1) begin errors++; $display("FAIL %s_busy_mid got %b exp 1", tag, bm); end
      idle(2, 1'b1, v);
      checks++; if (v !== 1'b0 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL %s_after got valid %b busy %b exp 0 0", tag, v, bus_if.busy); end
      checks++; if (bus_if.rx_data !== 8'hA5 || bus_if.parity_err !== exp_perr(8'hA5, p)) begin errors++; $display("FAIL %s_hold got %h/%b exp a5/%b", tag, bus_if.rx_data, bus_if.parity_err, exp_perr(8'hA5, p)); end
   endtask

   task automatic test_frame_err();
      int n, at; logic bm, v; logic [DATA_W-1:0] dp;
      send_frame(8'h3C, 1'b0, 1'b0, 0, n, at, bm, dp);
      checks++; if (n !== 1 || at !== strobe_no) begin errors++; $display("FAIL ferr_valid got count %0d at %0d exp 1 at %0d", n, at, strobe_no); end
      checks++; if (bus_if.rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h exp 3c", bus_if.rx_data); end
      checks++; if (bus_if.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", bus_if.frame_err); end
      checks++; if (bus_if.parity_err !== exp_perr(8'h3C, 1'b0)) begin errors++; $display("FAIL ferr_perr got %b exp %b", bus_if.parity_err, exp_perr(8'h3C, 1'b0)); end
      send_frame(8'h01, 1'b1, 1'b1, 0, n, at, bm, dp);
      checks++; if (n !== 1 || bus_if.rx_data !== 8'h01) begin errors++; $display("FAIL ferr_next got count %0d data %h exp 1 01", n, bus_if.rx_data); end
      checks++; if (bus_if.frame_err !== 1'b0 || bus_if.parity_err !== exp_perr(8'h01, 1'b1)) begin errors++; $display("FAIL ferr_next_flags got f%b p%b exp f0 p%b", bus_if.frame_err, bus_if.parity_err, exp_perr(8'h01, 1'b1)); end
      idle(1, 1'b0, v);
   endtask

   task automatic test_slow_strobe();
      int n, at; logic bm, v; logic [DATA_W-1:0] dp;
      send_frame(8'hFF, 1'b0, 1'b1, 3, n, at, bm, dp);
      checks++; if (n !== 1 || at !== strobe_no) begin errors++; $display("FAIL slow_valid got count %0d at %0d exp 1 at %0d", n, at, strobe_no); end
      checks++; if (bus_if.rx_data !== 8'hFF || bus_if.frame_err !== 1'b0 || bus_if.parity_err !== exp_perr(8'hFF, 1'b0)) begin
         errors++; $display("FAIL slow_word got %h f%b p%b exp ff f0 p%b", bus_if.rx_data, bus_if.frame_err, bus_if.parity_err, exp_perr(8'hFF, 1'b0)); end
      idle(3, 1'b0, v);
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL slow_pulse_width got extra valid %b exp 0", v); end
   endtask

   task automatic test_reset_mid();
      int n, at; logic bm, vg, ve, v; logic [DATA_W-1:0] dp;
      logic [DATA_W-1:0] w;
      w = 8'h55;
      strobe(START_BIT, 0, vg, ve);
      for (int i = 0; i < 4; i++) strobe(w[i], 0, vg, ve);
      @(negedge clk);
      rst_n = 1'b0; bus_if.bit_en = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus_if.busy !== 1'b0 || bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy %b valid %b exp 0 0", bus_if.busy, bus_if.rx_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2, 1'b1, v);
      checks++; if (v !== 1'b0 || bus_if.rx_data !== '0) begin errors++; $display("FAIL rstmid_idle got valid %b data %h exp 0 00", v, bus_if.rx_data); end
      send_frame(8'h0F, 1'b0, 1'b1, 1, n, at, bm, dp);
      checks++; if (dp !== '0) begin errors++; $display("FAIL rstmid_data_early got %h exp 00", dp); end
      checks++; if (n !== 1 || bus_if.rx_data !== 8'h0F || bus_if.parity_err !== exp_perr(8'h0F, 1'b0)) begin
         errors++; $display("FAIL rstmid_frame got count %0d data %h p%b exp 1 0f p%b", n, bus_if.rx_data, bus_if.parity_err, exp_perr(8'h0F, 1'b0)); end
      idle(1, 1'b0, v);
   endtask

   task automatic test_back_to_back();
      int n1, at1, n2, at2; logic bm, v; logic [DATA_W-1:0] dp, d1;
      send_frame(8'h12, 1'b0, 1'b1, 0, n1, at1, bm, dp);
      d1 = bus_if.rx_data;
      send_frame(8'h34, 1'b1, 1'b1, 0, n2, at2, bm, dp);
      checks++; if (n1 !== 1 || n2 !== 1 || at2 - at1 !== int'(FRAME_LEN)) begin
         errors++; $display("FAIL b2b_spacing got counts %0d/%0d gap %0d exp 1/1 %0d", n1, n2, at2 - at1, FRAME_LEN); end
      checks++; if (d1 !== 8'h12 || bus_if.rx_data !== 8'h34) begin errors++; $display("FAIL b2b_data got %h/%h exp 12/34", d1, bus_if.rx_data); end
      checks++; if (bus_if.parity_err !== exp_perr(8'h34, 1'b1)) begin errors++; $display("FAIL b2b_perr got %b exp %b", bus_if.parity_err, exp_perr(8'h34, 1'b1)); end
      idle(1, 1'b0, v);
   endtask

   task automatic test_random();
      int n, at; logic bm, v; logic [DATA_W-1:0] dp, d;
      logic p, s;
      for (int f = 0; f < 30; f++) begin
         d = DATA_W'($urandom);
         p = 1'($urandom);
         s = ($urandom_range(0, 3) != 0);
         send_frame(d, p, s, $urandom_range(0, 2), n, at, bm, dp);
         checks++; if (n !== 1 || at !== strobe_no) begin errors++; $display("FAIL rand%0d_valid got count %0d at %0d exp 1 at %0d", f, n, at, strobe_no); end
         checks++; if (bus_if.rx_data !== d || bus_if.parity_err !== exp_perr(d, p) || bus_if.frame_err !== ~s) begin
            errors++; $display("FAIL rand%0d_word got %h p%b f%b exp %h p%b f%b", f, bus_if.rx_data, bus_if.parity_err, bus_if.frame_err, d, exp_perr(d, p), ~s); end
         idle($urandom_range(0, 2), 1'($urandom), v);
      end
      idle(1, 1'b0, v);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus_if.bit_en = 1'b0;
      bus_if.sdi    = LINE_IDLE;
      test_reset();
      test_good_frame(1'b0, "good");
      test_good_frame(1'b1, "par1");
      test_frame_err();
      test_slow_strobe();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial frame receiver and parity checker. It is the receiving end of the XOR-parity serial link whose transmitter XOR-reduces each data word.
- Deserialises one start bit, DATA_W data bits (LSB first), one parity bit and one stop bit.
- Presents the word with parity and framing error flags.
- Sits between the line-sampling strobe logic and the downstream consumer.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 1..16).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- bit_en  input  1  sample strobe; sdi is consumed only in cycles where bit_en=1.
- sdi  input  1  serial data line; idle level 1.
- rx_data  output  DATA_W  received word; held until the next frame completes.
- rx_valid  output  1  one-cycle pulse when a frame completes, good or bad.
- parity_err  output  1  parity result of the last completed frame; valid with rx_valid, held after.
- frame_err  output  1  stop bit was 0 in the last completed frame; valid with rx_valid, held after.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, bit counter=0, running parity=0. Reset mid-frame aborts the frame with no rx_valid.
- Reset is synchronous only. Asserting rst_n between edges has no effect until the next rising clk.
- Cycles with bit_en=0 change no state and no outputs, except that rx_valid falls to 0.
- State machine, advancing only on bit_en=1:
  - IDLE: sdi=0 goes to DATA and clears the counter and parity accumulator. sdi=1 stays in IDLE.
  - DATA: shift sdi into bit[cnt] of a shift register (LSB first) and XOR it into the accumulator. When cnt reaches DATA_W-1, go to PARITY; otherwise cnt++.
  - PARITY: accumulator ^= sdi. Go to STOP.
  - STOP: rx_data <= shift register, parity_err <= accumulator (even parity: nonzero means error), frame_err <= ~sdi, rx_valid <= 1 for exactly one cycle. Go to IDLE.
- Latency: rx_valid rises on the clock edge that samples the stop bit. rx_data and the error flags update on that same edge.
- A frame with parity or framing error is still delivered; rx_data carries the received bits.
- Stop bit=0 with frame_err set: the next strobe in IDLE with sdi=0 starts a new frame. There is no break detection.
- No backpressure: rx_valid is a pulse, and the consumer must capture it that cycle.
- Back-to-back frames: STOP to IDLE to the next start bit needs no extra strobe beyond the start bit itself.
- busy is registered and high in DATA, PARITY and STOP.

Optional Feature:
- Macro PARITY_ODD_EN.
- Defined: odd parity. The accumulator resets to 1 at the start bit, so parity_err=1 when the XOR over data plus parity bit is 0.
- Undefined: even parity as described above.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package parity_link_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP) and the 2-bit state type;
  - constants LINE_IDLE=1 and START_BIT=0;
  - function parity_of(word) used by both the transmitter and the bench.
- Natural sub-module parity_accum: 1-bit XOR accumulator with clear/enable, reused by the transmitter.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- DATA_W=8, bit_en every cycle, frame 0,[0xA5 LSB first],parity=0,stop=1 -> rx_valid one pulse on the stop-bit edge, rx_data=0xA5, parity_err=0, frame_err=0.
- Same frame with parity bit=1 -> rx_data=0xA5, parity_err=1, frame_err=0. With PARITY_ODD_EN defined, parity=1 -> parity_err=0.
- Frame 0x3C, parity 0, stop bit=0 -> frame_err=1, parity_err=0, rx_valid pulses. The next frame 0x01, parity 1 decodes cleanly.
- bit_en asserted once every 4 cycles during frame 0xFF (parity 0), with sdi glitching on non-strobe cycles -> rx_data=0xFF, no error, rx_valid exactly one cycle.
- rst_n=0 for one edge after 4 data bits of frame 0x55 -> busy=0, no rx_valid. The following full frame 0x0F decodes correctly and rx_data changes only then.
- Two back-to-back frames 0x12 then 0x34 with no idle strobes between them -> two rx_valid pulses exactly 11 strobes apart with the correct data.
